// File: rtl/serial2parallel.sv
// Receive-side deserializer: gathers RATIO beats of BUS_NUM_I lanes into one
// BUS_NUM_O-lane word, pulsing data_valid_o per group and abort_o on a truncated group.
module serial2parallel #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_NUM_I  = 1,
    parameter int BUS_NUM_O  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            data_valid_i,
    input  logic [DATA_WIDTH*BUS_NUM_I-1:0] data_i,
    output logic                            data_valid_o,
    output logic [DATA_WIDTH*BUS_NUM_O-1:0] data_o,
    output logic                            abort_o
);

    localparam int RATIO = BUS_NUM_O / BUS_NUM_I;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [CW-1:0]                   cnt;
    logic [DATA_WIDTH*BUS_NUM_O-1:0] acc;
    logic [DATA_WIDTH*BUS_NUM_O-1:0] word_next;
    logic                            last_beat;

    assign last_beat = (cnt == CW'(RATIO - 1));

    // Accumulator with the current beat merged in; on the last beat this is the
    // complete word, so the final lanes come straight from data_i.
    always_comb begin
        word_next = acc;
        for (int i = 0; i < BUS_NUM_I; i++) begin
            word_next[(int'(cnt) + RATIO * i) * DATA_WIDTH +: DATA_WIDTH] =
                data_i[i * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            acc          <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            abort_o      <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            abort_o      <= 1'b0;
            if (data_valid_i) begin
                acc <= word_next;
                if (last_beat) begin
                    data_o       <= word_next;
                    data_valid_o <= 1'b1;
                    cnt          <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (cnt != '0) begin
                // Burst ended mid-group: drop the partial lanes, keep data_o.
                cnt     <= '0;
                abort_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial2parallel.sv
// Randomized bench for serial2parallel (1->8 and 2->8) against a beat-list
// reference model plus a transmitter/scoreboard round trip.
module tb_serial2parallel;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [7:0]  d1 = '0;
    logic [15:0] d2 = '0;
    logic        dv1, ab1, dv2, ab2;
    logic [63:0] q1o, q2o;

    always #5 clk = ~clk;

    serial2parallel #(.DATA_WIDTH(8), .BUS_NUM_I(1), .BUS_NUM_O(8)) dut (
        .clk(clk), .reset(reset), .data_valid_i(v1), .data_i(d1),
        .data_valid_o(dv1), .data_o(q1o), .abort_o(ab1));

    serial2parallel #(.DATA_WIDTH(8), .BUS_NUM_I(2), .BUS_NUM_O(8)) dut2 (
        .clk(clk), .reset(reset), .data_valid_i(v2), .data_i(d2),
        .data_valid_o(dv2), .data_o(q2o), .abort_o(ab2));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: beats received in the current group.
    logic [7:0]  beats1[$];
    logic [15:0] beats2[$];
    logic [63:0] e_word1 = '0, e_word2 = '0;
    logic        e_dv1 = 0, e_ab1 = 0, e_dv2 = 0, e_ab2 = 0;
    logic [63:0] sb1[$];
    logic [63:0] sb2[$];
    bit          rt_on = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        beats1.delete(); beats2.delete();
        e_word1 = '0; e_word2 = '0;
        e_dv1 = 0; e_ab1 = 0; e_dv2 = 0; e_ab2 = 0;
    endtask

    task automatic check_outputs();
        check("dv1", 64'(dv1), 64'(e_dv1));
        check("abort1", 64'(ab1), 64'(e_ab1));
        check("word1", q1o, e_word1);
        check("dv2", 64'(dv2), 64'(e_dv2));
        check("abort2", 64'(ab2), 64'(e_ab2));
        check("word2", q2o, e_word2);
    endtask

    // One clock: drive inputs, advance the model over the edge, compare.
    task automatic step(input logic iv1, input logic [7:0] id1,
                        input logic iv2, input logic [15:0] id2);
        v1 = iv1; d1 = id1; v2 = iv2; d2 = id2;
        @(posedge clk);
        #1;
        e_dv1 = 0; e_ab1 = 0;
        if (iv1) begin
            beats1.push_back(id1);
            if (beats1.size() == 8) begin
                for (int k = 0; k < 8; k++) e_word1[k*8 +: 8] = beats1[k];
                e_dv1 = 1;
                beats1.delete();
            end
        end else begin
            e_ab1 = (beats1.size() != 0);
            beats1.delete();
        end
        e_dv2 = 0; e_ab2 = 0;
        if (iv2) begin
            beats2.push_back(id2);
            if (beats2.size() == 4) begin
                for (int k = 0; k < 4; k++)
                    for (int i = 0; i < 2; i++)
                        e_word2[(k + 4*i)*8 +: 8] = beats2[k][i*8 +: 8];
                e_dv2 = 1;
                beats2.delete();
            end
        end else begin
            e_ab2 = (beats2.size() != 0);
            beats2.delete();
        end
        check_outputs();
        if (rt_on && dv1) begin
            if (sb1.size() == 0) check("rt1_extra_word", 64'd1, 64'd0);
            else check("rt1_word", q1o, sb1.pop_front());
        end
        if (rt_on && dv2) begin
            if (sb2.size() == 0) check("rt2_extra_word", 64'd1, 64'd0);
            else check("rt2_word", q2o, sb2.pop_front());
        end
    endtask

    task automatic idle1();
        step(1'b0, 8'($urandom), 1'b0, 16'($urandom));
    endtask

    initial begin
        logic [63:0] w;
        model_clear();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        // Single group 0x10..0x17
        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h10 + k), 1'b0, 16'h0);
        check("first_word_dv", 64'(dv1), 64'd1);
        check("first_word", q1o, 64'h1716151413121110);
        idle1();
        check("dv_single_pulse", 64'(dv1), 64'd0);

        // 24 continuous beats: pulses every 8 cycles
        for (int k = 0; k < 24; k++) step(1'b1, 8'(k), 1'b0, 16'h0);
        check("third_word", q1o, 64'h1716151413121110);
        idle1();

        // Truncated burst then full group
        for (int k = 0; k < 5; k++) step(1'b1, 8'(8'hA0 + k), 1'b0, 16'h0);
        idle1();
        check("abort_pulse", 64'(ab1), 64'd1);
        check("word_held_on_abort", q1o, 64'h1716151413121110);
        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'hB0 + k), 1'b0, 16'h0);
        check("word_after_abort", q1o, 64'hB7B6B5B4B3B2B1B0);
        idle1();

        // Two-lane input mapping on dut2
        step(1'b0, 8'h0, 1'b1, 16'h0400);
        step(1'b0, 8'h0, 1'b1, 16'h0501);
        step(1'b0, 8'h0, 1'b1, 16'h0602);
        step(1'b0, 8'h0, 1'b1, 16'h0703);
        check("two_lane_word", q2o, 64'h0706050403020100);
        idle1();

        // Async reset mid-group, then a fresh group
        for (int k = 0; k < 3; k++) step(1'b1, 8'(8'hE0 + k), 1'b1, 16'(16'hEE00 + k));
        #2;
        reset = 1'b1;
        v1 = 1'b0; v2 = 1'b0;
        #1;
        model_clear();
        check_outputs();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'hC0 + k), 1'b0, 16'h0);
        check("word_after_reset", q1o, 64'hC7C6C5C4C3C2C1C0);
        idle1();

        // Round trip: transmitter serializes random words, occasionally a
        // truncated burst is injected between groups.
        rt_on = 1;
        for (int g = 0; g < 1000; g++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 7)); k++)
                    step(1'b1, 8'($urandom), 1'b0, 16'h0);
                idle1();
            end
            w = {$urandom, $urandom};
            sb1.push_back(w);
            for (int k = 0; k < 8; k++) step(1'b1, w[k*8 +: 8], 1'b0, 16'h0);
            if ($urandom_range(0, 3) == 0) idle1();
        end
        for (int g = 0; g < 500; g++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                    step(1'b0, 8'h0, 1'b1, 16'($urandom));
                idle1();
            end
            w = {$urandom, $urandom};
            sb2.push_back(w);
            for (int k = 0; k < 4; k++) step(1'b0, 8'h0, 1'b1, {w[(k+4)*8 +: 8], w[k*8 +: 8]});
            if ($urandom_range(0, 3) == 0) idle1();
        end
        idle1();
        idle1();
        check("rt1_words_left", 64'(sb1.size()), 64'd0);
        check("rt2_words_left", 64'(sb2.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
